// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: UART transmitter fed by a small FIFO with a valid/ready
// front end. Queued words go out back-to-back with no idle gap between frames.
module uart_tx_buffered #(
  parameter int CLK_FREQ   = 24000000,
  parameter int BAUD_RATE  = 8000000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DATA_BITS-1:0]                 data_in,
  input  logic                                 data_valid,
  output logic                                 data_ready,
  output logic                                 tx,
  output logic                                 tx_busy,
  output logic                                 tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CLK_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CNT_W        = $clog2(FIFO_DEPTH + 1);

  localparam logic [CLK_W-1:0] CLK_LAST  = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic             PAR_SEED  = (PARITY_ODD != 0);
  localparam logic             HAS_PAR   = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] head;

  // Transmitter state
  state_t               state_q, state_d;
  logic [CLK_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 tx_d;
  logic                 done_d;
  logic                 bit_end;

  // Ready comes from the registered count only, so a pop in the same cycle
  // never frees a slot for that cycle's push.
  assign head       = mem[rd_ptr];
  assign fifo_empty = (fifo_count == '0);
  assign data_ready = ~rst & (fifo_count != FULL_CNT);
  assign push       = data_valid & data_ready;
  assign bit_end    = (clk_cnt_q == CLK_LAST);
  assign tx_busy    = (state_q != S_IDLE);

  // Write accepted words into the FIFO tail
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since depth is 2^n
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers, including the registered line output and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      tx        <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      tx        <= tx_d;
      tx_done   <= done_d;
    end
  end

  // Next-state, pop and next line value; a new word is loaded straight from
  // the final stop cycle so frames run back-to-back
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    pop       = 1'b0;
    done_d    = 1'b0;
    tx_d      = 1'b1;

    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (!fifo_empty) begin
          state_d = S_START;
          pop     = 1'b1;
          shreg_d = head;
          par_d   = (^head) ^ PAR_SEED;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == DATA_LAST) begin
            state_d   = HAS_PAR ? S_PARITY : S_STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d   = S_STOP;
          bit_cnt_d = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            done_d    = 1'b1;
            bit_cnt_d = '0;
            if (!fifo_empty) begin
              state_d = S_START;
              pop     = 1'b1;
              shreg_d = head;
              par_d   = (^head) ^ PAR_SEED;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: randomized and directed stimulus for uart_tx_buffered,
// checked cycle by cycle against a frame-level reference model.
module tb_uart_tx_buffered;

  localparam int CPB   = 24000000 / 8000000;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;
  logic [2:0] fifo_count;

  logic       rst_aux;
  logic [6:0] data_n;
  logic       valid_n, ready_n, tx_n, busy_n, done_n;
  logic [2:0] count_n;
  logic [7:0] data_o;
  logic       valid_o, ready_o, tx_o, busy_o, done_o;
  logic [2:0] count_o;

  int tests;
  int failed;
  int cyc;
  logic histTx [0:8191];

  // Reference model: queued words and the remaining per-cycle line samples
  logic [7:0] mq[$];
  logic       lq[$];
  logic       mdone;

  uart_tx_buffered dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done),
    .fifo_count(fifo_count)
  );

  uart_tx_buffered #(.DATA_BITS(7), .PARITY_EN(0), .STOP_BITS(2)) dut_n (
    .clk(clk), .rst(rst_aux), .data_in(data_n), .data_valid(valid_n),
    .data_ready(ready_n), .tx(tx_n), .tx_busy(busy_n), .tx_done(done_n),
    .fifo_count(count_n)
  );

  uart_tx_buffered #(.PARITY_ODD(1)) dut_o (
    .clk(clk), .rst(rst_aux), .data_in(data_o), .data_valid(valid_o),
    .data_ready(ready_o), .tx(tx_o), .tx_busy(busy_o), .tx_done(done_o),
    .fifo_count(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    if (observed !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Frame bits from the line format: start, LSB-first payload, parity, stops
  function automatic void build_frame(input logic [8:0] word, input int nbits,
                                      input int pen, input int podd, input int nstop,
                                      output logic [15:0] bits, output int nb);
    logic par;
    bits = '1;
    bits[0] = 1'b0;
    par = (podd != 0);
    for (int i = 0; i < nbits; i++) begin
      bits[1 + i] = word[i];
      par = par ^ word[i];
    end
    nb = 1 + nbits;
    if (pen != 0) begin
      bits[nb] = par;
      nb = nb + 1;
    end
    for (int s = 0; s < nstop; s++) begin
      bits[nb] = 1'b1;
      nb = nb + 1;
    end
  endfunction

  function automatic void startFrame();
    logic [15:0] bits;
    int nb;
    logic [7:0] w;
    w = mq.pop_front();
    build_frame({1'b0, w}, 8, 1, 0, 1, bits, nb);
    for (int b = 0; b < nb; b++) begin
      for (int r = 0; r < CPB; r++) begin
        lq.push_back(bits[b]);
      end
    end
  endfunction

  // Check this cycle's outputs, drive the next inputs, then advance the model
  // across the coming rising edge
  task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d);
    logic expTx, expBusy, expReady, doPush, nd;
    expTx    = (lq.size() > 0) ? lq[0] : 1'b1;
    expBusy  = (lq.size() > 0);
    expReady = !rst && (mq.size() < DEPTH);
    checkOutput("tx", {31'b0, tx}, {31'b0, expTx});
    checkOutput("tx_busy", {31'b0, tx_busy}, {31'b0, expBusy});
    checkOutput("tx_done", {31'b0, tx_done}, {31'b0, mdone});
    checkOutput("fifo_count", {29'b0, fifo_count}, mq.size());
    checkOutput("data_ready", {31'b0, data_ready}, {31'b0, expReady});
    if (cyc < 8192) histTx[cyc] = tx;
    cyc++;

    rst        = r;
    data_valid = v;
    data_in    = d;

    if (r) begin
      mq.delete();
      lq.delete();
      mdone = 1'b0;
    end else begin
      doPush = v && (mq.size() < DEPTH);
      nd = 1'b0;
      if (lq.size() > 0) begin
        void'(lq.pop_front());
        if (lq.size() == 0) begin
          nd = 1'b1;
          if (mq.size() > 0) startFrame();
        end
      end else if (mq.size() > 0) begin
        startFrame();
      end
      if (doPush) mq.push_back(d);
      mdone = nd;
    end
    @(negedge clk);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((lq.size() > 0 || mq.size() > 0) && n < limit) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      n++;
    end
    if (lq.size() > 0 || mq.size() > 0) checkOutput("drain_timeout", 0, 1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  // Narrow (7N2) and odd-parity instances, each sending one frame
  task automatic runAuxFrames();
    logic [15:0] bitsN, bitsO;
    int nbN, nbO;
    build_frame({2'b0, 7'h55}, 7, 0, 0, 2, bitsN, nbN);
    build_frame({1'b0, 8'h01}, 8, 1, 1, 1, bitsO, nbO);
    checkOutput("narrow_len", nbN * CPB, 30);
    valid_n = 1'b1; data_n = 7'h55;
    valid_o = 1'b1; data_o = 8'h01;
    @(negedge clk);
    valid_n = 1'b0; valid_o = 1'b0;
    checkOutput("narrow_count", {29'b0, count_n}, 1);
    checkOutput("odd_count", {29'b0, count_o}, 1);
    checkOutput("narrow_idle_tx", {31'b0, tx_n}, 1);
    for (int i = 0; i <= 33; i++) begin
      @(negedge clk);
      if (i < nbN * CPB) begin
        checkOutput($sformatf("narrow_tx%0d", i), {31'b0, tx_n}, {31'b0, bitsN[i / CPB]});
        checkOutput("narrow_busy", {31'b0, busy_n}, 1);
      end else if (i == nbN * CPB) begin
        checkOutput("narrow_done", {31'b0, done_n}, 1);
        checkOutput("narrow_busy_end", {31'b0, busy_n}, 0);
      end
      if (i < nbO * CPB) begin
        checkOutput($sformatf("odd_tx%0d", i), {31'b0, tx_o}, {31'b0, bitsO[i / CPB]});
      end else if (i == nbO * CPB) begin
        checkOutput("odd_done", {31'b0, done_o}, 1);
        checkOutput("odd_busy_end", {31'b0, busy_o}, 0);
      end
      if (i == 9 * CPB + 1) checkOutput("odd_parity_bit", {31'b0, tx_o}, 0);
    end
  endtask

  initial begin
    int p, n;
    logic sawDrop;
    logic [10:0] expSeq;
    logic [7:0] w;

    tests = 0; failed = 0; cyc = 0;
    mdone = 1'b0;
    rst = 1'b1; rst_aux = 1'b1;
    data_valid = 1'b0; data_in = 8'h00;
    valid_n = 1'b0; data_n = '0; valid_o = 1'b0; data_o = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset values while rst is high, then the first cycles after release
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    rst_aux = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);

    runAuxFrames();
    applyStimulus(1'b0, 1'b0, 8'h00);

    // Single frame 0xA5, checked bit by bit against the literal line pattern
    p = cyc;
    applyStimulus(1'b0, 1'b1, 8'hA5);
    repeat (40) applyStimulus(1'b0, 1'b0, 8'h00);
    expSeq = 11'b01010010101;
    for (int k = 0; k < 11; k++) begin
      checkOutput($sformatf("a5_bit%0d", k), {31'b0, histTx[p + 3 + 3 * k]},
                  {31'b0, expSeq[10 - k]});
    end

    // Back-to-back frames with backpressure, words 0x11..0x16
    sawDrop = 1'b0;
    n = 0;
    w = 8'h11;
    while (w <= 8'h16 && n < 400) begin
      if (!data_ready) sawDrop = 1'b1;
      if (mq.size() < DEPTH) begin
        applyStimulus(1'b0, 1'b1, w);
        w = w + 8'h01;
      end else begin
        applyStimulus(1'b0, 1'b1, w);
      end
      n++;
    end
    data_valid = 1'b0;
    checkOutput("bp_ready_drop", {31'b0, sawDrop}, 1);
    drain(400);

    // Reset during data bit 3 with two words queued
    applyStimulus(1'b0, 1'b1, 8'hC3);
    applyStimulus(1'b0, 1'b1, 8'h3C);
    applyStimulus(1'b0, 1'b1, 8'h99);
    n = 0;
    while (lq.size() > 20 && n < 50) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      n++;
    end
    checkOutput("pre_reset_count", {29'b0, fifo_count}, 2);
    applyStimulus(1'b1, 1'b0, 8'h00);
    repeat (40) applyStimulus(1'b0, 1'b0, 8'h00);

    // Push landing on the final stop cycle while one word is queued
    applyStimulus(1'b0, 1'b1, 8'h5A);
    applyStimulus(1'b0, 1'b1, 8'h01);
    n = 0;
    while (!(lq.size() == 1 && mq.size() == 1) && n < 80) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      n++;
    end
    if (lq.size() == 1 && mq.size() == 1) begin
      applyStimulus(1'b0, 1'b1, 8'hE7);
      checkOutput("pushpop_count", {29'b0, fifo_count}, 1);
      checkOutput("pushpop_start", {31'b0, tx}, 0);
      checkOutput("pushpop_done", {31'b0, tx_done}, 1);
    end else begin
      checkOutput("pushpop_wait", 0, 1);
    end
    drain(400);

    // Random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
                    8'($urandom));
    end
    drain(400);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
